// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle lookup, whole-line refill over a ready handshake.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        inp_clk,
  input  logic        inp_rst,
  input  logic        inp_req,
  input  logic [15:0] inp_addr,
  input  logic        inp_invalidate,
  output logic        out_hit,
  output logic [15:0] out_instruction,
  output logic        out_mem_req,
  output logic [15:0] out_mem_addr,
  input  logic        inp_mem_ready,
  input  logic [15:0] inp_mem_data,
  output logic [15:0] out_hit_count,
  output logic [15:0] out_miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 15 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_reg, state_next;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             unused_addr_lsb;

  logic             valid_reg [LINES];
  logic [TAG_W-1:0] tag_reg [LINES];
  logic [15:0]      data_mem [LINES*WORDS_PER_LINE];

  logic [TAG_W-1:0] miss_tag_reg;
  logic [IDX_W-1:0] miss_idx_reg;
  logic [OFF_W-1:0] cnt_reg;
  logic             mem_req_reg;
  logic [15:0]      mem_addr_reg;

  logic lookup_match;
  logic miss_start;
  logic word_write;
  logic line_fill;

  // Address split; bit 0 selects a byte inside a 16-bit instruction and is meaningless here.
  assign addr_tag        = inp_addr[15 -: TAG_W];
  assign addr_idx        = inp_addr[OFF_W+IDX_W -: IDX_W];
  assign addr_off        = inp_addr[OFF_W -: OFF_W];
  assign unused_addr_lsb = inp_addr[0];

  assign lookup_match = valid_reg[addr_idx] && (tag_reg[addr_idx] == addr_tag);

  // State register
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss_start) state_next = REFILL;
      REFILL:  if (line_fill)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    out_hit         = 1'b0;
    out_instruction = 16'h0000;
    miss_start      = 1'b0;
    word_write      = 1'b0;
    line_fill       = 1'b0;
    case (state_reg)
      IDLE: begin
        out_hit    = inp_req && lookup_match;
        miss_start = inp_req && !lookup_match;
        if (out_hit) begin
          out_instruction = data_mem[{addr_idx, addr_off}];
        end
      end
      REFILL: begin
        // Reset takes precedence over any memory write on the same edge.
        word_write = mem_req_reg && inp_mem_ready && !inp_rst;
        line_fill  = word_write && (cnt_reg == LAST_WORD);
      end
      default: ;
    endcase
  end

  // Refill address generator and handshake
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
      cnt_reg      <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= 16'h0000;
    end else if (miss_start) begin
      miss_tag_reg <= addr_tag;
      miss_idx_reg <= addr_idx;
      cnt_reg      <= '0;
      mem_req_reg  <= 1'b1;
      mem_addr_reg <= {addr_tag, addr_idx, {OFF_W{1'b0}}, 1'b0};
    end else if (word_write) begin
      if (line_fill) begin
        mem_req_reg <= 1'b0;
      end else begin
        cnt_reg      <= cnt_reg + OFF_W'(1);
        mem_addr_reg <= mem_addr_reg + 16'd2;
      end
    end
  end

  assign out_mem_req  = mem_req_reg;
  assign out_mem_addr = mem_addr_reg;

  // Instruction storage carries no reset; validity is tracked per line.
  always_ff @(posedge inp_clk) begin
    if (word_write) begin
      data_mem[{miss_idx_reg, cnt_reg}] <= inp_mem_data;
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      // Valid drops when a refill starts so a half-written line is never visible.
      always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (inp_invalidate) begin
          valid_reg[gi] <= 1'b0;
        end else if (miss_start && (addr_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (line_fill && (miss_idx_reg == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end

      always_ff @(posedge inp_clk) begin
        if (line_fill && (miss_idx_reg == IDX_W'(gi))) begin
          tag_reg[gi] <= miss_tag_reg;
        end
      end
    end
  endgenerate

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      hit_count_reg  <= 16'h0000;
      miss_count_reg <= 16'h0000;
    end else begin
      if (out_hit && (hit_count_reg != 16'hFFFF)) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (miss_start && (miss_count_reg != 16'hFFFF)) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign out_hit_count  = hit_count_reg;
  assign out_miss_count = miss_count_reg;
`else
  assign out_hit_count  = 16'h0000;
  assign out_miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus queues expected lookups and memory requests,
// a negedge monitor pops and compares them. Honors ICACHE_STATS_EN for the counter checks.
module tb_icache_direct;

  logic        clk;
  logic        inp_rst;
  logic        inp_req;
  logic [15:0] inp_addr;
  logic        inp_invalidate;
  logic        out_hit;
  logic [15:0] out_instruction;
  logic        out_mem_req;
  logic [15:0] out_mem_addr;
  logic        inp_mem_ready;
  logic [15:0] inp_mem_data;
  logic [15:0] out_hit_count;
  logic [15:0] out_miss_count;

  int tests = 0;
  int fails = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  bit quiet = 0;

  logic [16:0] look_q [$];
  logic [15:0] mem_q [$];

  icache_direct dut (
    .inp_clk         (clk),
    .inp_rst         (inp_rst),
    .inp_req         (inp_req),
    .inp_addr        (inp_addr),
    .inp_invalidate  (inp_invalidate),
    .out_hit         (out_hit),
    .out_instruction (out_instruction),
    .out_mem_req     (out_mem_req),
    .out_mem_addr    (out_mem_addr),
    .inp_mem_ready   (inp_mem_ready),
    .inp_mem_data    (inp_mem_data),
    .out_hit_count   (out_hit_count),
    .out_miss_count  (out_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: each word's contents encode its own word address.
  assign inp_mem_data = 16'hA000 ^ (out_mem_addr >> 1);

  function automatic logic [15:0] stat_exp(input int n);
`ifdef ICACHE_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n >= 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Monitor: compare every presented lookup and every active memory request cycle.
  always @(negedge clk) begin
    logic [16:0] le;
    logic [15:0] me;
    if (inp_req === 1'b1) begin
      tests++;
      if (look_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL lookup: unexpected request addr %h hit=%b", inp_addr, out_hit);
      end else begin
        le = look_q.pop_front();
        if ({out_hit, out_instruction} !== le) begin
          fails++;
          $display("[TB] FAIL lookup %h: got hit=%b instr=%h expected hit=%b instr=%h",
                   inp_addr, out_hit, out_instruction, le[16], le[15:0]);
        end else if (!quiet) begin
          $display("[TB] lookup %h hit=%b instr=%h", inp_addr, out_hit, out_instruction);
        end
      end
    end
    if (out_mem_req === 1'b1) begin
      tests++;
      if (mem_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL mem_req: unexpected request addr %h", out_mem_addr);
      end else begin
        me = mem_q.pop_front();
        if (out_mem_addr !== me) begin
          fails++;
          $display("[TB] FAIL mem_addr: got %h expected %h", out_mem_addr, me);
        end else begin
          $display("[TB] mem_req addr %h ready=%b", out_mem_addr, inp_mem_ready);
        end
      end
    end
  end

  task automatic step(input logic req, input logic [15:0] addr, input logic exp_hit,
                      input logic [15:0] exp_instr, input logic ready, input logic inv);
    inp_req        = req;
    inp_addr       = addr;
    inp_mem_ready  = ready;
    inp_invalidate = inv;
    if (req) begin
      look_q.push_back({exp_hit, exp_instr});
      if (exp_hit) exp_hits++;
    end
    @(posedge clk);
    #1;
    inp_req        = 1'b0;
    inp_invalidate = 1'b0;
  endtask

  task automatic miss(input logic [15:0] addr);
    step(1'b1, addr, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_misses++;
  endtask

  // Drive a refill with a ready pattern (bit i = cycle i); expect the held/advancing address each cycle.
  task automatic refill(input logic [15:0] base, input logic [7:0] pat, input int n,
                        input logic probe, input logic [15:0] probe_addr, input int inv_at);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      mem_q.push_back(base + 16'(2 * k));
      if (pat[i]) k++;
      step(probe, probe_addr, 1'b0, 16'h0000, pat[i], 1'(i == inv_at));
    end
    inp_mem_ready = 1'b0;
    check("mem_q drained", 16'(mem_q.size()), 16'd0);
  endtask

  initial begin
    inp_rst        = 1'b1;
    inp_req        = 1'b0;
    inp_addr       = 16'h0000;
    inp_invalidate = 1'b0;
    inp_mem_ready  = 1'b0;
    @(posedge clk);
    #1;
    // Lookup while reset is held: nothing is valid.
    step(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    inp_rst = 1'b0;
    check("reset mem_req", {15'd0, out_mem_req}, 16'd0);
    check("reset mem_addr", out_mem_addr, 16'h0000);
    check("reset hit_count", out_hit_count, 16'h0000);
    check("reset miss_count", out_miss_count, 16'h0000);

    // Cold miss on 0x0000, full refill, then hits.
    miss(16'h0000);
    refill(16'h0000, 8'b0000_1111, 4, 1'b0, 16'h0000, -1);
    step(1'b1, 16'h0004, 1'b1, 16'hA002, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 16'hA000, 1'b0, 1'b0);
    step(1'b1, 16'h0007, 1'b1, 16'hA003, 1'b1, 1'b0);

    // Same index, new tag evicts line 0.
    miss(16'h0080);
    refill(16'h0080, 8'b0000_1111, 4, 1'b0, 16'h0000, -1);
    step(1'b1, 16'h0082, 1'b1, 16'hA041, 1'b0, 1'b0);
    miss(16'h0000);
    refill(16'h0000, 8'b0000_1111, 4, 1'b0, 16'h0000, -1);
    step(1'b1, 16'h0002, 1'b1, 16'hA001, 1'b0, 1'b0);
    check("hit_count after evict", out_hit_count, stat_exp(exp_hits));
    check("miss_count after evict", out_miss_count, stat_exp(exp_misses));

    // Stalling memory; probe a valid line throughout to prove hits are suppressed.
    miss(16'h0008);
    refill(16'h0008, 8'b0101_1001, 7, 1'b1, 16'h0002, -1);
    step(1'b1, 16'h0008, 1'b1, 16'hA004, 1'b0, 1'b0);
    step(1'b1, 16'h000A, 1'b1, 16'hA005, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b1, 16'hA006, 1'b0, 1'b0);
    step(1'b1, 16'h000E, 1'b1, 16'hA007, 1'b0, 1'b0);

    // Invalidate in IDLE: same cycle still hits, next cycle misses.
    step(1'b1, 16'h0002, 1'b1, 16'hA001, 1'b0, 1'b1);
    miss(16'h0002);
    refill(16'h0000, 8'b0000_1111, 4, 1'b0, 16'h0000, 3);
    miss(16'h0002);
    refill(16'h0000, 8'b0000_1111, 4, 1'b0, 16'h0000, 1);
    step(1'b1, 16'h0002, 1'b1, 16'hA001, 1'b0, 1'b0);

    // Reset in the second refill cycle abandons the refill.
    miss(16'h0010);
    mem_q.push_back(16'h0010);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    mem_q.push_back(16'h0012);
    inp_rst = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    inp_rst       = 1'b0;
    inp_mem_ready = 1'b0;
    exp_hits      = 0;
    exp_misses    = 0;
    check("mem_req after reset", {15'd0, out_mem_req}, 16'd0);
    check("miss_count after reset", out_miss_count, 16'h0000);
    miss(16'h0010);
    refill(16'h0010, 8'b0000_1111, 4, 1'b0, 16'h0000, -1);
    step(1'b1, 16'h0012, 1'b1, 16'hA009, 1'b0, 1'b0);
    check("hit_count after refill", out_hit_count, stat_exp(exp_hits));

    // Long hit run to reach counter saturation.
    quiet = 1'b1;
`ifdef ICACHE_STATS_EN
    for (int i = 0; i < 65540; i++) step(1'b1, 16'h0012, 1'b1, 16'hA009, 1'b0, 1'b0);
`else
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0012, 1'b1, 16'hA009, 1'b0, 1'b0);
`endif
    quiet = 1'b0;
    check("hit_count final", out_hit_count, stat_exp(exp_hits));
    check("miss_count final", out_miss_count, stat_exp(exp_misses));
    check("lookup queue drained", 16'(look_q.size()), 16'd0);
    check("mem queue drained", 16'(mem_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the Fetch stage and the slow instruction memory.
- Serves 16-bit instructions on a same-cycle lookup and drives the hit flag that Fetch uses to stall the PC.
- On a miss, it refills the whole line from memory over a one-outstanding-request ready handshake.
- Byte-addressed PC with 16-bit instructions; address bit 0 is ignored.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 16-bit words per line (power of 2, ≥2).
- Derived widths:
  - OFF_W = log2(WORDS_PER_LINE), word offset = addr[OFF_W:1].
  - IDX_W = log2(LINES), index = addr[OFF_W+IDX_W:OFF_W+1].
  - TAG = remaining upper bits.

Ports:
- inp_clk  in  1  clock, all state updates on rising edge.
- inp_rst  in  1  synchronous active-high reset.
- inp_req  in  1  Fetch lookup request valid.
- inp_addr  in  16  fetch byte address (PC).
- inp_invalidate  in  1  one-cycle pulse, clears all valid bits.
- out_hit  out  1  instruction valid this cycle (combinational).
- out_instruction  out  16  instruction word, 0 when out_hit=0.
- out_mem_req  out  1  memory read request (registered).
- out_mem_addr  out  16  memory byte address, bit0=0 (registered).
- inp_mem_ready  in  1  memory data valid for current request.
- inp_mem_data  in  16  memory read data.
- out_hit_count  out  16  hit counter (see Optional Feature).
- out_miss_count  out  16  miss counter (see Optional Feature).

Behaviour:
- Storage:
  - valid[LINES], tag[LINES], data[LINES][WORDS_PER_LINE].
  - The data array itself is not reset.
- Reset (inp_rst=1 at an edge):
  - state=IDLE, all valid=0, out_mem_req=0, out_mem_addr=0, counters=0.
  - out_hit is therefore 0 and out_instruction is 0.
  - Reset mid-refill abandons the refill; the line stays invalid and out_mem_req is 0 after that edge.
- Lookup (combinational):
  - out_hit = inp_req & (state==IDLE) & valid[idx] & (tag[idx]==addr tag).
  - out_instruction = data[idx][off] when out_hit, else 16'h0000.
- FSM states: IDLE, REFILL.
- IDLE:
  - If inp_req and lookup misses: latch miss tag/index, word counter=0, then next edge:
    - out_mem_req=1, out_mem_addr={tag,idx,0,1'b0}, state=REFILL.
  - If inp_req=0 or the lookup hits, stay in IDLE.
- REFILL:
  - out_hit is forced 0 regardless of inp_addr; the latched miss address is used, and inp_addr changes are ignored.
  - Each edge with inp_mem_ready=1:
    - data[idx][cnt] <= inp_mem_data.
    - If cnt < WORDS_PER_LINE-1: cnt++ and out_mem_addr advances by 2 (out_mem_req stays 1).
    - Else (last word): tag[idx] <= latched tag, valid[idx] <= 1, out_mem_req <= 0, state <= IDLE.
  - inp_mem_ready=0: hold all refill state.
  - inp_mem_ready is ignored while out_mem_req=0.
- Latency:
  - Hit: 0 cycles (same cycle as request).
  - Miss with ready always 1: out_mem_req is high for WORDS_PER_LINE cycles, and the first hit occurs WORDS_PER_LINE+1 edges after the miss cycle.
- Eviction: a miss on an occupied index overwrites that line; valid is cleared at refill start, so a partial line is never visible.
- inp_invalidate:
  - Clears all valid bits at the edge.
  - In IDLE, takes effect the next cycle.
  - During REFILL, the refill continues and the refilled line becomes valid at completion.
  - If asserted on the same edge as the final refill write, invalidate wins and the line ends invalid.
- Priority: inp_rst > inp_invalidate > refill writes.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - out_hit_count increments on each edge where out_hit=1.
  - out_miss_count increments on each IDLE→REFILL transition.
  - Both saturate at 16'hFFFF and are reset to 0.
- Undefined: both ports remain, tied to 16'h0000, and no counter registers are built.

Test Plan:
1. Reset, then inp_req=1, inp_addr=16'h0000 with mem ready=1 and data 16'hA000..A003 → out_mem_addr sequence 0000,0002,0004,0006; then a hit at 0x0004 returns 16'hA002.
2. After test 1, request 16'h0080 (same index 0, new tag; ready=1) → miss, refill 0080..0086; then 0x0000 misses again (evicted).
3. Refill with inp_mem_ready toggled 1,0,0,1,1,0,1 → exactly 4 words written in order, out_mem_addr holds during ready=0, and out_hit=0 throughout REFILL.
4. Line 0 valid, pulse inp_invalidate → next-cycle request to 0x0002 misses; invalidate coincident with the last refill word → line stays invalid.
5. Assert inp_rst in the 2nd refill cycle → out_mem_req=0 next cycle, state IDLE, and a re-request of the same address misses.
6. With ICACHE_STATS_EN: run tests 1 and 2 → out_miss_count=3 and out_hit_count equals the hit cycles counted; force 65536+ hits → out_hit_count holds at 16'hFFFF. Without the macro, both counters read 0.
